// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon round checker.
package simon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCheck = 2'd1,
        StPass  = 2'd2,
        StFail  = 2'd3
    } chk_state_t;

    localparam int unsigned KEY_W         = 2;
    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    localparam logic [7:0]  SEED_FALLBACK = 8'h01;

endpackage

// File: rtl/simon_lfsr.sv
// Fibonacci LFSR (taps 8,6,5,4), shifts left with feedback into bit 0.
// Load has priority over step.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;
    logic [W-1:0] taps;
    logic         fb;

    assign taps = W'(LFSR_TAPS);

    always_comb begin
        fb  = ^(q_q & taps);
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = {q_q[W-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= W'(SEED_FALLBACK);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/round_checker.sv
// Replays a round's key sequence from the latched seed and checks player strobes against it.
// Optional ROUND_TIMEOUT_EN adds an inactivity timeout and a sticky timeout output.
module round_checker
    import simon_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LEN_W       = 5,
    parameter int unsigned SEED_W      = 8
`ifdef ROUND_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed,
    input  logic              seed_load,
    input  logic              round_start,
    input  logic [LEN_W-1:0]  round_len,
    input  logic              key_strobe,
    input  logic [KEY_W-1:0]  key_code,
    output logic [KEY_W-1:0]  exp_key,
    output logic              exp_valid,
    output logic [LEN_W-1:0]  key_idx,
    output logic              round_passed,
    output logic              mismatch,
    output logic              busy
`ifdef ROUND_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    chk_state_t        state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_fix, start_seed, lfsr_q;
    logic [LEN_W-1:0]  len_q, len_clamp, idx_q, idx_inc;
    logic              passed_q, mism_q;
    logic              seed_take, accept, hit, miss, last, tmo_hit;

    assign seed_fix   = (seed == '0) ? SEED_W'(SEED_FALLBACK) : seed;
    assign seed_take  = (state_q == StIdle) && seed_load;
    // A seed loaded alongside round_start is used for that same round.
    assign start_seed = seed_take ? seed_fix : seed_q;

    always_comb begin
        len_clamp = round_len;
        if (round_len == '0) begin
            len_clamp = LEN_W'(1);
        end else if (round_len > LEN_W'(DEPTH)) begin
            len_clamp = LEN_W'(DEPTH);
        end
    end

    assign accept  = (state_q == StCheck) && key_strobe && !round_start;
    assign hit     = accept && (key_code == lfsr_q[KEY_W-1:0]);
    assign miss    = accept && !hit;
    assign idx_inc = idx_q + LEN_W'(1);
    assign last    = (idx_inc == len_q);

`ifdef ROUND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             timeout_q;

    assign tmo_hit = (state_q == StCheck) && !round_start && !accept &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (round_start || accept) begin
                tmo_q <= '0;
            end else if (state_q == StCheck) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (round_start) begin
                timeout_q <= 1'b0;
            end else if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
`endif

    simon_lfsr #(
        .W (SEED_W)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (round_start),
        .load_val (start_seed),
        .step     (hit),
        .q        (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (round_start) begin
            state_d = StCheck;
        end else if (state_q == StCheck) begin
            if (hit && last) begin
                state_d = StPass;
            end else if (miss || tmo_hit) begin
                state_d = StFail;
            end
        end
    end

    always_comb begin
        busy      = 1'b0;
        exp_valid = 1'b0;
        exp_key   = '0;
        if (state_q == StCheck) begin
            busy      = 1'b1;
            exp_valid = 1'b1;
            exp_key   = lfsr_q[KEY_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_q   <= SEED_W'(SEED_FALLBACK);
            len_q    <= LEN_W'(1);
            idx_q    <= '0;
            passed_q <= 1'b0;
            mism_q   <= 1'b0;
        end else begin
            if (seed_take) begin
                seed_q <= seed_fix;
            end
            if (round_start) begin
                len_q    <= len_clamp;
                idx_q    <= '0;
                passed_q <= 1'b0;
                mism_q   <= 1'b0;
            end else if (hit) begin
                idx_q <= idx_inc;
                if (last) begin
                    passed_q <= 1'b1;
                end
            end else if (miss || tmo_hit) begin
                mism_q <= 1'b1;
            end
        end
    end

    assign key_idx      = idx_q;
    assign round_passed = passed_q;
    assign mismatch     = mism_q;

endmodule

// File: tb/tb_round_checker.sv
// Directed self-checking bench for round_checker; build with ROUND_TIMEOUT_EN to cover the timeout.
module tb_round_checker;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned SEED_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [SEED_W-1:0] seed = '0;
    logic              seed_load = 1'b0;
    logic              round_start = 1'b0;
    logic [LEN_W-1:0]  round_len = '0;
    logic              key_strobe = 1'b0;
    logic [1:0]        key_code = '0;
    logic [1:0]        exp_key;
    logic              exp_valid;
    logic [LEN_W-1:0]  key_idx;
    logic              round_passed;
    logic              mismatch;
    logic              busy;
`ifdef ROUND_TIMEOUT_EN
    logic              timeout;
`endif

    int errors = 0;
    int checks = 0;

    round_checker #(
        .DEPTH       (DEPTH),
        .LEN_W       (LEN_W),
        .SEED_W      (SEED_W)
`ifdef ROUND_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (10)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seed         (seed),
        .seed_load    (seed_load),
        .round_start  (round_start),
        .round_len    (round_len),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .exp_key      (exp_key),
        .exp_valid    (exp_valid),
        .key_idx      (key_idx),
        .round_passed (round_passed),
        .mismatch     (mismatch),
        .busy         (busy)
`ifdef ROUND_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] code);
        key_code   = code;
        key_strobe = 1'b1;
        tick();
        key_strobe = 1'b0;
    endtask

    task automatic start(input logic [LEN_W-1:0] len);
        round_len   = len;
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        tick();
    endtask

    // Reference step straight from the tap list 8,6,5,4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [1:0] seq01 [5] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd1};
    logic [7:0] s;

    initial begin
        #12;
        check_eq("rst_state", dut.state_q, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", exp_valid, 0);
        check_eq("rst_idx", key_idx, 0);
        check_eq("rst_passed", round_passed, 0);
        check_eq("rst_mism", mismatch, 0);
        check_eq("rst_expkey", exp_key, 0);
        rst = 1'b1;
        tick();

        // Seed 5A, length 3: sequence 2,0,1
        seed      = 8'h5A;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        start(5'd3);
        check_eq("a_busy", busy, 1);
        check_eq("a_exp0", exp_key, 2);
        press(2'd2);
        check_eq("a_idx1", key_idx, 1);
        check_eq("a_exp1", exp_key, 0);
        press(2'd0);
        check_eq("a_exp2", exp_key, 1);
        press(2'd1);
        check_eq("a_passed", round_passed, 1);
        check_eq("a_idx3", key_idx, 3);
        check_eq("a_mism", mismatch, 0);
        check_eq("a_state", dut.state_q, 2);

        // Same seed, length 4, wrong second key
        start(5'd4);
        check_eq("b_passed_clr", round_passed, 0);
        press(2'd2);
        press(2'd3);
        check_eq("b_mism", mismatch, 1);
        check_eq("b_idx", key_idx, 1);
        check_eq("b_state", dut.state_q, 3);
        press(2'd0);
        check_eq("b_hold_idx", key_idx, 1);
        check_eq("b_hold_mism", mismatch, 1);
        check_eq("b_hold_passed", round_passed, 0);
        check_eq("b_hold_state", dut.state_q, 3);

        // round_start wins over a same-cycle key, then async reset mid-round
        key_code    = 2'd2;
        key_strobe  = 1'b1;
        round_len   = 5'd3;
        round_start = 1'b1;
        tick();
        key_strobe  = 1'b0;
        round_start = 1'b0;
        check_eq("c_idx", key_idx, 0);
        check_eq("c_exp", exp_key, 2);
        check_eq("c_mism_clr", mismatch, 0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("c_rst_state", dut.state_q, 0);
        check_eq("c_rst_busy", busy, 0);
        check_eq("c_rst_exp", exp_key, 0);
        check_eq("c_rst_idx", key_idx, 0);
        rst = 1'b1;
        tick();
        start(5'd1);
        check_eq("c_seed_lost", exp_key, 1);

        // Zero seed falls back to 01
        pulse_reset();
        seed      = 8'h00;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        start(5'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("d_exp%0d", i), exp_key, seq01[i]);
            press(seq01[i]);
        end
        check_eq("d_passed", round_passed, 1);
        check_eq("d_idx", key_idx, 5);

        // Length 0 clamps to 1
        start(5'd0);
        press(2'd1);
        check_eq("e_passed", round_passed, 1);
        check_eq("e_idx", key_idx, 1);

        // Length 20 clamps to DEPTH
        start(5'd20);
        s = 8'h01;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("f_exp%0d", i), exp_key, s[1:0]);
            if (i == 15) begin
                check_eq("f_not_yet", round_passed, 0);
                check_eq("f_busy15", busy, 1);
            end
            press(s[1:0]);
            s = lfsr_step(s);
        end
        check_eq("f_passed", round_passed, 1);
        check_eq("f_idx", key_idx, 16);
        check_eq("f_busy", busy, 0);

        // seed_load together with round_start in IDLE uses the new seed
        pulse_reset();
        seed        = 8'h5A;
        seed_load   = 1'b1;
        round_len   = 5'd1;
        round_start = 1'b1;
        tick();
        seed_load   = 1'b0;
        round_start = 1'b0;
        check_eq("g_bypass", exp_key, 2);

`ifdef ROUND_TIMEOUT_EN
        start(5'd3);
        repeat (9) tick();
        check_eq("t_early", mismatch, 0);
        tick();
        check_eq("t_mism", mismatch, 1);
        check_eq("t_timeout", timeout, 1);
        check_eq("t_state", dut.state_q, 3);
`else
        start(5'd3);
        repeat (1000) tick();
        check_eq("t_busy", busy, 1);
        check_eq("t_state", dut.state_q, 1);
        check_eq("t_mism", mismatch, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_checker.md
Name: round_checker

Overview:
- Sits directly upstream of the game controller.
- Regenerates the round's pseudo-random key sequence from a latched seed and exposes the expected key for the display path.
- Compares each player key strobe against that sequence.
- Produces the round_passed / mismatch status the controller samples at the end of PLAY.

Parameters:
- DEPTH, 16, maximum sequence length per round (1..31).
- LEN_W, 5, width of the round length and index (must hold DEPTH).
- SEED_W, 8, LFSR/seed width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- seed  input  SEED_W  game seed, sampled on seed_load.
- seed_load  input  1  one-cycle pulse; captures seed (IDLE only).
- round_start  input  1  one-cycle pulse; begins checking a round.
- round_len  input  LEN_W  number of keys in this round, sampled on round_start.
- key_strobe  input  1  one-cycle pulse per debounced key press.
- key_code  input  2  pressed button, 0..3.
- exp_key  output  2  expected key at the current index.
- exp_valid  output  1  high in CHECK.
- key_idx  output  LEN_W  number of keys matched so far.
- round_passed  output  1  sticky pass flag.
- mismatch  output  1  sticky fail flag.
- busy  output  1  high in CHECK.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; seed_q=8'h01; all outputs 0; key_idx=0; exp_key=0.
- States: IDLE, CHECK, PASS, FAIL (encoded 0..3).
- Seed handling:
  - seed_load is honoured only in IDLE.
  - seed_q<=seed, except seed==0, which loads 8'h01 (LFSR lock-up guard).
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit 0.
  - exp_key = lfsr[1:0].
- round_start:
  - Accepted in any state.
  - Next cycle: lfsr<=seed_q; key_idx<=0; flags cleared; len_q<=clamp(round_len); state<=CHECK.
  - clamp: 0 becomes 1; values >DEPTH become DEPTH.
  - Every round replays the same prefix.
- CHECK, on key_strobe:
  - key_code==exp_key: key_idx<=key_idx+1; lfsr steps once.
  - If key_idx+1==len_q, state<=PASS and round_passed<=1 on the same edge.
  - Mismatch: state<=FAIL; mismatch<=1; key_idx and lfsr hold.
- Latency:
  - Flags are registered and visible one cycle after the strobe edge.
  - exp_key updates in the same cycle.
- PASS and FAIL:
  - Flags hold until the next round_start or reset.
  - key_strobe is ignored.
- IDLE: key_strobe ignored; exp_valid=0.
- round_start together with key_strobe: round_start wins and the key is dropped.
- seed_load together with round_start in IDLE: the new seed is used for this round (bypass).
- Reset mid-round: immediate return to IDLE with seed_q=8'h01; the prior seed is lost.
- round_passed and mismatch are never high together.

Optional Feature:
- Macro ROUND_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT_CYC (default 50_000_000) and a counter exist.
  - The counter is cleared on entry to CHECK and on each accepted key.
  - If it reaches TIMEOUT_CYC-1 in CHECK: state<=FAIL, mismatch<=1.
  - An extra output port timeout (1 bit, sticky like mismatch) is present.
- When undefined: no counter and no timeout port; CHECK waits indefinitely.

Decomposition:
- Package simon_pkg holds:
  - chk_state_t enum (IDLE, CHECK, PASS, FAIL).
  - KEY_W=2.
  - LFSR_TAPS=8'hB8.
  - SEED_FALLBACK=8'h01.
- One sub-module, simon_lfsr:
  - Ports: clk, rst, load, load_val, step, q.
  - Async active-low reset to SEED_FALLBACK.
- round_checker instantiates simon_lfsr and implements the FSM, index and flag logic.

Test Plan:
- Seed 8'h5A, round_len=3, player enters the three exp_key values → round_passed=1 one cycle after the 3rd strobe; key_idx=3; mismatch=0.
- Same seed, round_len=4, wrong code on the 2nd key → mismatch=1, key_idx=1, state FAIL; later strobes leave everything unchanged.
- seed_load with seed=0, then round_start → exp_key sequence equals that of seed 8'h01; no LFSR lock-up.
- round_len=0 → one correct key passes. round_len=20 with DEPTH=16 → pass only after 16 keys.
- round_start and key_strobe in the same cycle, then rst pulled low mid-CHECK → key dropped, key_idx=0; after reset all outputs 0, state IDLE.
- With ROUND_TIMEOUT_EN, TIMEOUT_CYC=10, no keys after round_start → mismatch=1 and timeout=1 after 10 cycles. Without the macro → still CHECK after 1000 cycles.
